// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode bit positions and the
// minimum SCLK half-period (in system clocks) the master's divider must honour.
package spi_pkg;

    typedef logic state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    // Bit positions inside the 2-bit {cpol, cpha} mode word.
    localparam int CPOL = 1;
    localparam int CPHA = 0;

    // SCLK high/low time floor, in clk cycles, for the slave's oversampling.
    localparam int SPI_MIN_HALF = 4;

endpackage

// File: rtl/spi_slave_if.sv
// Word-side bus of the SPI slave.
//   tx_data/tx_valid/tx_ready : transmit word handshake into the holding register
//   rx_data/rx_valid          : received word and its one-cycle strobe
//   tx_underrun, frame_abort  : one-cycle status pulses
//   busy                      : frame in progress
// Modports: slave = the SPI slave block, master = the system-side user.
interface spi_slave_if #(parameter int WIDTH = 8);

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             tx_underrun;
    logic             frame_abort;
    logic             busy;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus one extra register used
// for rise/fall detection.
//   clk, rst  : system clock, synchronous active-high reset
//   d         : asynchronous input
//   q         : synchronized level (2 flops)
//   rise/fall : single-cycle edge strobes on q
// RST_VAL sets the level all three flops take in reset.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= {3{RST_VAL}};
        else     ff <= {ff[1:0], d};
    end

    assign q    = ff[1];
    assign rise = ff[1] & ~ff[2];
    assign fall = ~ff[1] & ff[2];

endmodule

// File: rtl/spi_slave.sv
// SPI slave transceiver, MSB-first, full duplex, WIDTH-bit words, all four
// cpol/cpha modes. SPI pins are oversampled in the clk domain.
//   clk, rst                 : system clock, synchronous active-high reset
//   mode                     : {cpol, cpha}, latched at frame start
//   bus (spi_slave_if.slave) : tx holding-register handshake, rx word, status
//   spi_clk, cs_n, spi_data_in : SCLK, slave select (active low), MOSI
//   spi_data_out, spi_data_oe  : MISO and its pad output enable
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    spi_slave_if.slave bus,
    input  logic       spi_clk,
    input  logic       cs_n,
    input  logic       spi_data_in,
    output logic       spi_data_out,
    output logic       spi_data_oe
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level_unused, cs_rise, cs_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(spi_clk),
        .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // cs_n resets to the selected level: if the pin is already low when rst
    // drops, no fall is seen and the rest of that frame is ignored until
    // cs_n rises and falls again.
    spi_sync_edge #(.RST_VAL(1'b0)) u_cs (
        .clk(clk), .rst(rst), .d(cs_n),
        .q(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(spi_data_in),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t           state, state_nxt;
    logic [1:0]       mode_q;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] rx_data_q;
    logic             done_q, rx_valid_q, underrun_q, abort_q;

    logic start, active, lead, trail, sample_e, shift_e, word_end, reload;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_data_out = 1'b1;
        spi_data_oe  = 1'b0;
        bus.busy     = 1'b0;
        if (state == SHIFT) begin
            spi_data_out = tx_shift[WIDTH-1];
            spi_data_oe  = 1'b1;
            bus.busy     = 1'b1;
        end
    end

    // ---------------- edge decode ----------------
    assign start    = (state == IDLE) && cs_fall;
    assign active   = (state == SHIFT) && !cs_rise;
    assign lead     = mode_q[CPOL] ? sclk_fall : sclk_rise;
    assign trail    = mode_q[CPOL] ? sclk_rise : sclk_fall;
    assign sample_e = active && (mode_q[CPHA] ? trail : lead);
    assign shift_e  = active && (mode_q[CPHA] ? lead : trail);
    assign word_end = sample_e && (bit_cnt == CNT_LAST);
    // cpha=1 reloads on the last sample edge; cpha=0 on the shift edge after it.
    assign reload   = start || (mode_q[CPHA] ? word_end
                                             : (shift_e && bit_cnt == CNT_FULL));
    assign rx_next  = {rx_shift, mosi_q};

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 2'b00;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rx_valid_q <= done_q;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;

            if (start) mode_q <= mode;

            if (reload) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift   <= '1;
                    underrun_q <= 1'b1;
                end
            end else if (shift_e && bit_cnt != '0) begin
                // bit_cnt==0 here is the first cpha=1 leading edge: MSB stays.
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end

            if (start) begin
                bit_cnt <= '0;
            end else if (sample_e) begin
                rx_shift <= rx_next[WIDTH-2:0];
                if (word_end) begin
                    rx_data_q <= rx_next;
                    done_q    <= 1'b1;
                    bit_cnt   <= mode_q[CPHA] ? '0 : CNT_FULL;
                end else if (bit_cnt != CNT_FULL) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (shift_e && bit_cnt == CNT_FULL) begin
                bit_cnt <= '0;
            end

            if (state == SHIFT && cs_rise && bit_cnt != '0 && bit_cnt != CNT_FULL)
                abort_q <= 1'b1;

            // A write only lands in an empty register, so it never collides
            // with a reload that is emptying a full one.
            if (bus.tx_valid && !hold_full) begin
                hold      <= bus.tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign bus.tx_ready    = ~hold_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench plays the SPI master on the pins
// and the system user on the word bus.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W = 8;
    localparam int H = SPI_MIN_HALF + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       spi_clk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, oe;

    spi_slave_if #(.WIDTH(W)) bus ();

    spi_slave #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .bus(bus.slave),
        .spi_clk(spi_clk), .cs_n(cs_n), .spi_data_in(mosi),
        .spi_data_out(miso), .spi_data_oe(oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] rx_q[$];
    int           uc_q[$];
    int           uc_cnt = 0;
    int           ab_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_q.push_back(bus.rx_data);
            uc_q.push_back(uc_cnt);
        end
        if (bus.tx_underrun) uc_cnt++;
        if (bus.frame_abort) ab_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        int k = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && k < 1000) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= 1000) $display("FAIL tx_write_timeout: tx_ready stayed %b, want 1", bus.tx_ready);
        else passes++;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic cs_start(input logic [1:0] m);
        mode    = m;
        spi_clk = m[CPOL];
        tick(8);
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_end();
        tick(H);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        if (!mode[CPHA]) begin
            mosi = b;
            tick(H);
            r = miso;
            spi_clk = ~mode[CPOL];
            tick(H);
            spi_clk = mode[CPOL];
        end else begin
            spi_clk = ~mode[CPOL];
            mosi = b;
            tick(H);
            r = miso;
            spi_clk = mode[CPOL];
            tick(H);
        end
    endtask

    task automatic xfer_word(input logic [W-1:0] w, output logic [W-1:0] r);
        logic b;
        for (int i = W - 1; i >= 0; i--) begin
            xfer_bit(w[i], b);
            r[i] = b;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({bus.tx_ready, bus.rx_valid, bus.tx_underrun, bus.frame_abort, bus.busy, miso, oe} !== 7'b1000010)
            $display("FAIL %s_flags: got rdy/rv/ur/ab/busy/miso/oe=%b, want 1000010", tag,
                     {bus.tx_ready, bus.rx_valid, bus.tx_underrun, bus.frame_abort, bus.busy, miso, oe});
        else passes++;
        checks++;
        if (bus.rx_data !== 8'h00) $display("FAIL %s_rx_data: got %h, want 00", tag, bus.rx_data);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_vals("reset");
    endtask

    task automatic test_mode0();
        logic [W-1:0] r;
        int rb, ub;
        tx_write(8'hA5);
        checks++;
        if (bus.tx_ready !== 1'b0) $display("FAIL m0_ready_after_write: got %b, want 0", bus.tx_ready);
        else passes++;
        rb = rx_q.size();
        ub = uc_cnt;
        cs_start(2'b00);
        checks++;
        if ({bus.busy, oe, bus.tx_ready} !== 3'b111)
            $display("FAIL m0_in_frame: got busy/oe/ready=%b, want 111", {bus.busy, oe, bus.tx_ready});
        else passes++;
        xfer_word(8'h3C, r);
        cs_end();
        checks++;
        if (r !== 8'hA5) $display("FAIL m0_miso: got %h, want a5", r);
        else passes++;
        checks++;
        if (rx_q.size() !== rb + 1) $display("FAIL m0_rx_count: got %0d, want %0d", rx_q.size() - rb, 1);
        else passes++;
        checks++;
        if (bus.rx_data !== 8'h3C) $display("FAIL m0_rx_data: got %h, want 3c", bus.rx_data);
        else passes++;
        if (uc_q.size() > 0) begin
            checks++;
            if (uc_q[$] !== ub) $display("FAIL m0_underrun: got %0d pulses, want 0", uc_q[$] - ub);
            else passes++;
        end
        checks++;
        if ({bus.busy, oe, miso} !== 3'b001)
            $display("FAIL m0_idle_after: got busy/oe/miso=%b, want 001", {bus.busy, oe, miso});
        else passes++;
    endtask

    task automatic test_modes();
        logic [W-1:0] r;
        int rb;
        for (int m = 1; m < 4; m++) begin
            tx_write(8'hA5);
            rb = rx_q.size();
            cs_start(2'(m));
            xfer_word(8'h3C, r);
            cs_end();
            checks++;
            if (r !== 8'hA5) $display("FAIL mode%0d_miso: got %h, want a5", m, r);
            else passes++;
            checks++;
            if (bus.rx_data !== 8'h3C || rx_q.size() !== rb + 1)
                $display("FAIL mode%0d_rx: got %h x%0d, want 3c x1", m, bus.rx_data, rx_q.size() - rb);
            else passes++;
        end
    endtask

    task automatic test_underrun();
        logic [W-1:0] r0, r1;
        int rb, ub;
        tx_write(8'h11);
        rb = rx_q.size();
        ub = uc_cnt;
        cs_start(2'b00);
        xfer_word(8'h81, r0);
        xfer_word(8'h7E, r1);
        cs_end();
        checks++;
        if ({r0, r1} !== 16'h11FF) $display("FAIL ur_miso: got %h %h, want 11 ff", r0, r1);
        else passes++;
        checks++;
        if (rx_q.size() !== rb + 2) $display("FAIL ur_rx_count: got %0d, want 2", rx_q.size() - rb);
        else begin
            passes++;
            checks++;
            if ({rx_q[rb], rx_q[rb+1]} !== 16'h817E)
                $display("FAIL ur_rx_words: got %h %h, want 81 7e", rx_q[rb], rx_q[rb+1]);
            else passes++;
            checks++;
            if (uc_q[rb] !== ub || uc_q[rb+1] !== ub + 1)
                $display("FAIL ur_pulses: got %0d then %0d, want 0 then 1", uc_q[rb] - ub, uc_q[rb+1] - ub);
            else passes++;
        end
    endtask

    task automatic test_abort();
        logic b;
        logic [W-1:0] r;
        int rb, ab;
        rb = rx_q.size();
        ab = ab_cnt;
        cs_start(2'b00);
        for (int i = 0; i < 5; i++) begin
            xfer_bit(i[0], b);
            if (i == 1) tx_write(8'hC3);
        end
        cs_end();
        checks++;
        if (ab_cnt !== ab + 1) $display("FAIL abort_pulse: got %0d, want 1", ab_cnt - ab);
        else passes++;
        checks++;
        if (rx_q.size() !== rb || bus.rx_data !== 8'h7E)
            $display("FAIL abort_rx: got %h x%0d, want 7e x0", bus.rx_data, rx_q.size() - rb);
        else passes++;
        cs_start(2'b00);
        xfer_word(8'h96, r);
        cs_end();
        checks++;
        if (r !== 8'hC3 || bus.rx_data !== 8'h96 || ab_cnt !== ab + 1)
            $display("FAIL abort_next: got miso %h rx %h aborts %0d, want c3 96 1", r, bus.rx_data, ab_cnt - ab);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r0, r1, r2;
        int rb, ub;
        tx_write(8'h44);
        rb = rx_q.size();
        ub = uc_cnt;
        cs_start(2'b00);
        tx_write(8'h22);
        checks++;
        if (bus.tx_ready !== 1'b0) $display("FAIL b2b_ready: got %b, want 0", bus.tx_ready);
        else passes++;
        fork
            begin
                xfer_word(8'h01, r0);
                xfer_word(8'h02, r1);
                xfer_word(8'h03, r2);
            end
            tx_write(8'h33);
        join
        cs_end();
        checks++;
        if ({r0, r1, r2} !== 24'h442233) $display("FAIL b2b_miso: got %h %h %h, want 44 22 33", r0, r1, r2);
        else passes++;
        checks++;
        if (rx_q.size() !== rb + 3) $display("FAIL b2b_rx_count: got %0d, want 3", rx_q.size() - rb);
        else begin
            passes++;
            checks++;
            if (uc_q[rb+2] !== ub) $display("FAIL b2b_underrun: got %0d, want 0", uc_q[rb+2] - ub);
            else passes++;
        end
    endtask

    task automatic test_rst_mid();
        logic b;
        logic [W-1:0] r;
        int rb, ab;
        tx_write(8'h99);
        cs_start(2'b00);
        for (int i = 0; i < 3; i++) xfer_bit(1'b1, b);
        rst = 1'b1;
        tick(1);
        check_reset_vals("rst_mid");
        rst = 1'b0;
        rb = rx_q.size();
        ab = ab_cnt;
        for (int i = 0; i < 5; i++) xfer_bit(1'b0, b);
        cs_end();
        checks++;
        if (rx_q.size() !== rb || ab_cnt !== ab || bus.busy !== 1'b0)
            $display("FAIL rst_mid_ignored: got rx %0d aborts %0d busy %b, want 0 0 0",
                     rx_q.size() - rb, ab_cnt - ab, bus.busy);
        else passes++;
        cs_start(2'b00);
        xfer_word(8'h5A, r);
        cs_end();
        checks++;
        if (bus.rx_data !== 8'h5A || r !== 8'hFF)
            $display("FAIL rst_fresh: got rx %h miso %h, want 5a ff", bus.rx_data, r);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave transceiver for MSB-first, full-duplex frames of WIDTH bits in any of the four SPI modes (cpol/cpha). It sits on the peripheral side of the SPI link, opposite our SPI master. All SPI pins are treated as asynchronous and oversampled in the system clock domain. Received words go out on a valid-pulse bus, and transmit words come in through a one-deep holding register with a ready/valid handshake.

## Interface
- WIDTH, 8, frame word width in bits (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- mode  in  2  {cpol, cpha}; latched at frame start
- tx_data  in  WIDTH  word to send on MISO
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; write occurs when tx_valid && tx_ready
- rx_data  out  WIDTH  last complete received word; held until the next word completes
- rx_valid  out  1  one-cycle pulse, rx_data updated
- tx_underrun  out  1  one-cycle pulse: word boundary with empty holding register
- frame_abort  out  1  one-cycle pulse: cs_n rose with a partial word pending
- busy  out  1  frame in progress (synchronized cs_n low)
- spi_clk  in  1  SCLK from master
- cs_n  in  1  slave select, active-low
- spi_data_in  in  1  MOSI
- spi_data_out  out  1  MISO
- spi_data_oe  out  1  MISO output enable (pad tristate control)

## Operation
- spi_clk, cs_n, and spi_data_in each pass through a 2-flop synchronizer. spi_clk and cs_n also pass through edge detection, which adds one register stage.
- Leading edge = transition away from cpol; trailing edge = transition back to cpol.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on a synced cs_n fall.
  - SHIFT -> IDLE on a synced cs_n rise.
  - rst forces IDLE.
- On IDLE -> SHIFT:
  - Latch mode.
  - Clear bit_cnt.
  - Load the shift register from the holding register if it is full, which empties it. If it is empty, load all-ones and pulse tx_underrun.
- While in SHIFT, spi_data_out = tx_shift[WIDTH-1] and spi_data_oe = 1. In IDLE, spi_data_out = 1 and spi_data_oe = 0.
- cpha=0:
  - Sample edge = leading, shift edge = trailing.
  - Sample edge: shift the synced MOSI into rx_shift and increment bit_cnt.
  - Shift edge: tx_shift <<= 1. If bit_cnt == WIDTH, reload tx_shift instead of shifting, and clear bit_cnt.
- cpha=1:
  - Sample edge = trailing, shift edge = leading.
  - The first leading edge of each word does not shift.
  - The WIDTH-th sample edge reloads tx_shift and clears bit_cnt.
- Word completion (WIDTH-th sample): rx_data <= {rx_shift[WIDTH-2:0], mosi}, and rx_valid pulses on the next cycle. There is no receive backpressure.
- Reload rule:
  - Reload uses the holding register state at the start of the cycle.
  - A tx write in the same cycle fills the register after the reload, so it is kept for the next word.
  - Reload from an empty register sends all-ones and pulses tx_underrun.
- bit_cnt width is $clog2(WIDTH)+1. It never exceeds WIDTH.
- cs_n rise with 0 < bit_cnt < WIDTH:
  - Discard the partial word.
  - Pulse frame_abort.
  - rx_data is unchanged.
  - The holding register is unaffected.
- mode changes while in SHIFT are ignored.

## Timing
- Reset values:
  - tx_ready=1, rx_valid=0, rx_data=0, tx_underrun=0, frame_abort=0, busy=0.
  - spi_data_out=1, spi_data_oe=0.
  - Holding register empty, shift registers 0.
- Pin-to-action latency is 3 clk cycles (2 sync + 1 edge detect).
- Requirements on the master:
  - SCLK high and low times ≥ 4 clk cycles.
  - cs_n fall to first SCLK edge ≥ 4 clk cycles.
- With those constraints, MISO settles ≥1 clk before the master's sample edge.
- rx_valid asserts 4 clk cycles after the pin-level WIDTH-th sample edge.
- tx_ready deasserts the cycle after the write. It reasserts the cycle after a load empties the holding register.
- busy follows the synced cs_n, so it lags the pin by 3 clk cycles.
- rst mid-frame:
  - Immediate return to IDLE and all reset values.
  - No rx_valid or frame_abort pulse.
  - The remainder of the current frame is ignored until cs_n rises and falls again.

## Structure
- Shared package spi_pkg holds:
  - FSM state localparams IDLE/SHIFT.
  - Mode bit indices CPOL=1, CPHA=0.
  - Minimum half-period constant SPI_MIN_HALF=4, shared with the master's divider.
- One sub-module, spi_sync_edge:
  - Parameterized 2-flop synchronizer plus rise/fall detector on clk/rst.
  - Instanced for spi_clk and cs_n.
  - MOSI uses the synchronizer only, with its edge outputs unused.

## Test plan
- Mode 0, tx write 0xA5 before cs_n fall, master sends 0x3C: MISO shows 10100101, rx_data=0x3C with a single rx_valid pulse, tx_underrun never pulses.
- Modes 1, 2, 3, same words, back-to-back against our SPI master: identical rx_data=0x3C, master receives 0xA5 in each mode.
- Two-word frame with only 0x11 written: second word on MISO is 0xFF, tx_underrun pulses once at the word boundary, both rx words delivered.
- cs_n rises after 5 bits: frame_abort pulses once, no rx_valid, rx_data keeps its previous value; next full frame receives correctly.
- tx write in the same cycle as a reload (0x22 held, 0x33 written): 0x22 is sent, 0x33 stays held and is sent on the next word, tx_ready low throughout.
- rst asserted mid-word: next cycle all outputs are at reset values; a fresh frame of 0x5A is then received correctly.
